// File: rtl/ad_channel_averager.sv
// Per-channel boxcar averager for the ADC SPI frame stream: demultiplexes frames
// by channel, averages 2^LOG2_AVG samples and publishes each result into a readable bank.
module ad_channel_averager #(
  parameter int LOG2_AVG = 4,
  parameter int DATA_W   = 12,
  parameter int CH_W     = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [15:0]       Frame_Data,
  input  logic              Frame_Strobe,
  input  logic              Data_Valid,
  input  logic              Enable,
  input  logic              Clear,
  output logic              Avg_Valid,
  output logic [CH_W-1:0]   Avg_Channel,
  output logic [DATA_W-1:0] Avg_Data,
  input  logic [CH_W-1:0]   Rd_Channel,
  output logic [DATA_W-1:0] Rd_Data,
  output logic [7:0]        Frame_Err_Cnt
);

  localparam int NCH   = 1 << CH_W;
  localparam int ACC_W = DATA_W + LOG2_AVG;
  localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << LOG2_AVG) - 1);

  // Strobe synchroniser plus edge register; all idle high so reset cannot fake an edge.
  logic sync1_reg, sync2_reg, sync3_reg;
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      sync3_reg <= 1'b1;
    end else begin
      sync1_reg <= Frame_Strobe;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
    end
  end

  logic rise, accept, err_hit;
  assign rise    = sync2_reg & ~sync3_reg;
  assign accept  = rise & Data_Valid & Enable & ~Frame_Data[15] & ~Clear;
  assign err_hit = rise & Data_Valid & Enable & Frame_Data[15];

  logic              frame_vld_reg;
  logic [CH_W-1:0]   frame_ch_reg;
  logic [DATA_W-1:0] frame_smp_reg;
  logic [7:0]        err_cnt_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_vld_reg <= 1'b0;
      frame_ch_reg  <= '0;
      frame_smp_reg <= '0;
      err_cnt_reg   <= '0;
    end else begin
      frame_vld_reg <= accept;
      if (accept) begin
        frame_ch_reg  <= Frame_Data[DATA_W +: CH_W];
        frame_smp_reg <= Frame_Data[DATA_W-1:0];
      end
      if (err_hit && (err_cnt_reg != 8'hFF))
        err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end
  assign Frame_Err_Cnt = err_cnt_reg;

  logic [ACC_W-1:0]  acc_vec [NCH];
  logic [CNT_W-1:0]  cnt_vec [NCH];
  logic [DATA_W-1:0] res_vec [NCH];

  logic [ACC_W-1:0]  sum_next;
  logic              win_done;
  logic [DATA_W-1:0] avg_next;
  assign sum_next = acc_vec[frame_ch_reg] + ACC_W'(frame_smp_reg);
  assign win_done = frame_vld_reg && (cnt_vec[frame_ch_reg] == CNT_MAX);
  assign avg_next = DATA_W'(sum_next >> LOG2_AVG);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic              hit;
      logic [ACC_W-1:0]  acc_reg;
      logic [CNT_W-1:0]  cnt_reg;
      logic [DATA_W-1:0] res_reg;

      assign hit = frame_vld_reg && (frame_ch_reg == CH_W'(gi));

      // Clear overrides an in-flight update of the window state only.
      always_ff @(posedge CLK) begin
        if (RST || Clear) begin
          acc_reg <= '0;
          cnt_reg <= '0;
        end else if (hit) begin
          if (win_done) begin
            acc_reg <= '0;
            cnt_reg <= '0;
          end else begin
            acc_reg <= sum_next;
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge CLK) begin
        if (RST)
          res_reg <= '0;
        else if (hit && win_done)
          res_reg <= avg_next;
      end

      assign acc_vec[gi] = acc_reg;
      assign cnt_vec[gi] = cnt_reg;
      assign res_vec[gi] = res_reg;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      Avg_Valid   <= 1'b0;
      Avg_Channel <= '0;
      Avg_Data    <= '0;
      Rd_Data     <= '0;
    end else begin
      Avg_Valid <= win_done;
      if (win_done) begin
        Avg_Channel <= frame_ch_reg;
        Avg_Data    <= avg_next;
      end
      Rd_Data <= res_vec[Rd_Channel];
    end
  end

endmodule

// File: tb/tb_ad_channel_averager.sv
// Bench for ad_channel_averager: two instances (LOG2_AVG=4 and 0) share stimulus and
// are compared every cycle against a per-channel sum/count model.
module tb_ad_channel_averager;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] Frame_Data = '0;
  logic        Frame_Strobe = 1'b1;
  logic        Data_Valid = 1'b0;
  logic        Enable = 1'b0;
  logic        Clear = 1'b0;
  logic [2:0]  Rd_Channel = '0;

  logic        av4, av0;
  logic [2:0]  ch4, ch0;
  logic [11:0] d4, d0, rd4, rd0;
  logic [7:0]  err4, err0;

  always #5 CLK = ~CLK;

  ad_channel_averager #(.LOG2_AVG(4), .DATA_W(12), .CH_W(3)) dut4 (
    .CLK(CLK), .RST(RST), .Frame_Data(Frame_Data), .Frame_Strobe(Frame_Strobe),
    .Data_Valid(Data_Valid), .Enable(Enable), .Clear(Clear),
    .Avg_Valid(av4), .Avg_Channel(ch4), .Avg_Data(d4),
    .Rd_Channel(Rd_Channel), .Rd_Data(rd4), .Frame_Err_Cnt(err4));

  ad_channel_averager #(.LOG2_AVG(0), .DATA_W(12), .CH_W(3)) dut0 (
    .CLK(CLK), .RST(RST), .Frame_Data(Frame_Data), .Frame_Strobe(Frame_Strobe),
    .Data_Valid(Data_Valid), .Enable(Enable), .Clear(Clear),
    .Avg_Valid(av0), .Avg_Channel(ch0), .Avg_Data(d0),
    .Rd_Channel(Rd_Channel), .Rd_Data(rd0), .Frame_Err_Cnt(err0));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] ch;
    logic [11:0] d;
  } exp_t;

  // Model: index 0 is the 16-sample instance, index 1 the single-sample one.
  int          lg [2] = '{4, 0};
  int          sum [2][8];
  int          n   [2][8];
  logic [11:0] res [2][8];
  int          err_m = 0;
  exp_t        q [2][$];

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 8; c++) begin
        sum[k][c] = 0;
        n[k][c]   = 0;
        res[k][c] = '0;
      end
      q[k].delete();
    end
    err_m = 0;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 8; c++) begin
        sum[k][c] = 0;
        n[k][c]   = 0;
      end
  endtask

  // t = cycle count at the negedge the strobe rose; the average appears 4 counts later.
  task automatic model_frame(input logic [2:0] ch, input logic [11:0] s, input bit bad,
                             input bit dv, input bit en, input int t);
    exp_t e;
    if (dv && en && bad && err_m < 255) err_m++;
    if (dv && en && !bad) begin
      for (int k = 0; k < 2; k++) begin
        sum[k][ch] += int'(s);
        n[k][ch]++;
        if (n[k][ch] == (1 << lg[k])) begin
          e.cyc = t + 4;
          e.ch  = ch;
          e.d   = 12'(sum[k][ch] >> lg[k]);
          res[k][ch] = e.d;
          q[k].push_back(e);
          sum[k][ch] = 0;
          n[k][ch]   = 0;
        end
      end
    end
  endtask

  task automatic cmp(input int k, input logic v, input logic [2:0] c, input logic [11:0] d);
    exp_t e;
    bit   hit = 1'b0;
    if (q[k].size() > 0 && q[k][0].cyc == cyc) begin
      hit = 1'b1;
      e = q[k].pop_front();
    end
    chk(k == 0 ? "avg_valid_l4" : "avg_valid_l0", int'(v), int'(hit));
    if (hit) begin
      chk(k == 0 ? "avg_channel_l4" : "avg_channel_l0", int'(c), int'(e.ch));
      chk(k == 0 ? "avg_data_l4" : "avg_data_l0", int'(d), int'(e.d));
    end
  endtask

  always @(negedge CLK) begin
    cmp(0, av4, ch4, d4);
    cmp(1, av0, ch0, d0);
  end

  task automatic send(input logic [2:0] ch, input logic [11:0] s, input bit bad,
                      input bit dv, input bit en);
    @(negedge CLK);
    Data_Valid   = dv;
    Enable       = en;
    Frame_Data   = {bad, ch, s};
    Frame_Strobe = 1'b0;
    repeat (3) @(negedge CLK);
    Frame_Strobe = 1'b1;
    model_frame(ch, s, bad, dv, en, cyc);
    $display("frame ch=%0d smp=%03h bad=%0d dv=%0d en=%0d", ch, s, bad, dv, en);
    repeat (6) @(negedge CLK);
  endtask

  task automatic pulse_clear();
    @(negedge CLK);
    Clear = 1'b1;
    @(negedge CLK);
    Clear = 1'b0;
    model_clear();
    $display("clear");
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    model_reset();
    $display("reset");
  endtask

  task automatic rd(input logic [2:0] ch, output logic [11:0] r4, output logic [11:0] r0);
    @(negedge CLK);
    Rd_Channel = ch;
    @(negedge CLK);
    r4 = rd4;
    r0 = rd0;
    $display("read ch=%0d l4=%03h l0=%03h", ch, r4, r0);
  endtask

  task automatic rd_all();
    logic [11:0] a, b;
    for (int c = 0; c < 8; c++) begin
      rd(3'(c), a, b);
      chk("rd_data_l4", int'(a), int'(res[0][c]));
      chk("rd_data_l0", int'(b), int'(res[1][c]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] a, b;
    model_reset();
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    chk("reset_avg_data", int'(d4), 0);
    chk("reset_err_cnt", int'(err4), 0);
    rd_all();

    // 16 ramp samples on channel 2
    for (int i = 0; i < 16; i++) send(3'd2, 12'(16'h100 + i), 0, 1, 1);
    chk("ramp_avg_lit", int'(d4), 12'h107);
    chk("ramp_ch_lit", int'(ch4), 2);
    rd(3'd2, a, b);
    chk("ramp_rd_lit", int'(a), 12'h107);

    // Interleaved extremes on channels 0 and 7
    for (int i = 0; i < 16; i++) begin
      send(3'd0, 12'hFFF, 0, 1, 1);
      send(3'd7, 12'h001, 0, 1, 1);
    end
    chk("ilv_ch7_lit", int'(d4), 12'h001);
    rd(3'd0, a, b);
    chk("ilv_ch0_lit", int'(a), 12'hFFF);

    // Partial window then Clear
    for (int i = 0; i < 8; i++) send(3'd3, 12'h800, 0, 1, 1);
    pulse_clear();
    for (int i = 0; i < 16; i++) send(3'd3, 12'h010, 0, 1, 1);
    chk("clear_avg_lit", int'(d4), 12'h010);
    rd_all();

    // Error frames saturate the counter; invalid frames are ignored
    for (int i = 0; i < 300; i++) send(3'($urandom_range(0, 7)), 12'($urandom), 1, 1, 1);
    chk("err_sat_lit", int'(err4), 255);
    chk("err_sat_l0", int'(err0), err_m);
    send(3'd4, 12'h123, 1, 0, 1);
    send(3'd4, 12'h456, 0, 0, 1);
    send(3'd4, 12'h789, 0, 1, 0);
    chk("err_hold", int'(err4), 255);
    rd_all();

    // Single-sample instance, then reset in the middle of a channel 1 window
    send(3'd5, 12'hABC, 0, 1, 1);
    chk("l0_avg_lit", int'(d0), 12'hABC);
    for (int i = 0; i < 5; i++) send(3'd1, 12'hFFF, 0, 1, 1);
    do_reset();
    for (int i = 0; i < 16; i++) send(3'd1, 12'h020, 0, 1, 1);
    chk("rst_avg_lit", int'(d4), 12'h020);
    chk("rst_err_lit", int'(err4), 0);

    // Randomised traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int r = int'($urandom_range(0, 63));
      if (r == 0) pulse_clear();
      send(3'($urandom_range(0, 7)), 12'($urandom), r inside {[1:4]},
           !(r inside {[5:11]}), !(r inside {[12:18]}));
    end
    chk("rand_err_l4", int'(err4), err_m);
    chk("rand_err_l0", int'(err0), err_m);
    rd_all();

    repeat (4) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ad_channel_averager.md
Name: ad_channel_averager

Overview:
- Downstream consumer of the ADC SPI frame stream: the 16-bit result word (bit 15 = 0, [14:12] = channel address, [11:0] = sample) and the chip-select strobe whose rising edge marks each completed frame.
- Demultiplexes frames by channel and keeps a per-channel boxcar accumulator.
- Emits a decimated average per channel, 2^LOG2_AVG samples per result, stored in a readable result bank.
- Feeds display/BCD conversion with noise-reduced values instead of raw samples.

Parameters:
- LOG2_AVG, 4, log2 of samples averaged per result; legal range 0..8.
- DATA_W, 12, sample width.
- CH_W, 3, channel address width (2^CH_W channels).

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- Frame_Data  in  16  ADC result word: [15] = must be 0, [14:12] = channel, [11:0] = sample; stable around the strobe rising edge.
- Frame_Strobe  in  1  ADC chip-select, asynchronous to CLK, idles high; rising edge = frame complete.
- Data_Valid  in  1  high when upstream frames carry conversion data (not configuration echoes).
- Enable  in  1  accept frames when high.
- Clear  in  1  synchronous pulse: zero all accumulators and counters.
- Avg_Valid  out  1  one-cycle pulse when a new average is produced.
- Avg_Channel  out  3  channel of the average.
- Avg_Data  out  12  average value.
- Rd_Channel  in  3  result-bank read address.
- Rd_Data  out  12  result-bank read data, 1-cycle latency.
- Frame_Err_Cnt  out  8  saturating count of frames with bit 15 set.

Behaviour:
- Reset values:
  - Strobe synchroniser (2 flops) and edge register reset to 1, so no spurious edge after reset.
  - All outputs, accumulators, counters and the result bank reset to 0.
- Edge detect: rise = sync2 & ~sync3. Define cycle E as the cycle in which rise is high.
- Accept condition, evaluated in E: Data_Valid & Enable & ~Frame_Data[15] & ~Clear.
  - On accept: capture Frame_Data into the frame register at the end of E.
  - If rise & Data_Valid & Enable & Frame_Data[15]: increment Frame_Err_Cnt, saturating at 255; discard the frame.
- Accumulate, cycle E+1, for channel ch = captured [14:12]:
  - acc[ch] (width DATA_W+LOG2_AVG) += sample; cnt[ch] (width LOG2_AVG) += 1.
  - If cnt[ch] == 2^LOG2_AVG-1 before the increment, the window is complete: result[ch] <= (acc[ch]+sample) >> LOG2_AVG (truncate, no rounding); acc[ch] <= 0; cnt[ch] <= 0.
  - On window completion, Avg_Valid = 1 during E+2, with Avg_Channel/Avg_Data held from then until the next pulse.
- Latency: strobe rising edge to Avg_Valid is 2-3 CLK cycles of synchroniser plus 2 cycles of pipeline.
- LOG2_AVG = 0: every accepted frame produces Avg_Valid; Avg_Data equals the sample.
- No overflow by construction: sum of max 4095 × 2^LOG2_AVG fits DATA_W+LOG2_AVG bits.
- Clear:
  - Zeroes every acc and cnt at the end of the cycle it is high.
  - Result bank, Frame_Err_Cnt and Avg_* are untouched.
  - A frame whose E coincides with Clear is dropped.
  - Clear coinciding with an in-flight E+1 update: Clear wins for acc/cnt, but a completing window still writes result and pulses Avg_Valid.
- Enable low: frames ignored; partial accumulations retained and resumed when Enable returns.
- Channel interleaving: each channel's window is independent; any arrival order is valid.
- Back-to-back frames: the frame period greatly exceeds the pipeline depth; no back-pressure exists.
- Read port: Rd_Data <= result[Rd_Channel] each cycle. If the same entry is written in the same cycle, the old value is returned (read-before-write).
- RST mid-window: all partial sums lost; first post-reset window starts clean; no Avg_Valid within 2 cycles of RST deasserting.

Test Plan:
- Reset, hold Frame_Strobe high, release RST -> no Avg_Valid, Rd_Data = 0 for every channel.
- LOG2_AVG=4, 16 frames ch 2 with samples 0x100..0x10F, Data_Valid=Enable=1 -> single Avg_Valid, Avg_Channel=2, Avg_Data=0x107; read ch 2 returns 0x107 one cycle later.
- Interleave ch0=0xFFF and ch7=0x001, 16 frames each alternating -> two Avg_Valid pulses: ch0 0xFFF, ch7 0x001; no cross-contamination.
- 8 frames ch 3 of 0x800, pulse Clear, then 16 frames of 0x010 -> Avg_Data=0x010 (pre-Clear samples discarded); results of other channels unchanged.
- Frames with bit 15 set, 300 times -> Frame_Err_Cnt saturates at 255, no accumulator change; Data_Valid=0 frames -> ignored, Frame_Err_Cnt unchanged.
- LOG2_AVG=0, frame ch5 0xABC -> Avg_Valid with 0xABC exactly 2 cycles after edge detect; RST asserted mid-window for ch1 at LOG2_AVG=4 -> next average uses only post-reset samples.
